// File: rtl/mux151_scan_ctrl.sv
// Scan sequencer for a 74LS151-style 8-to-1 selector: walks all eight channels and
// returns them as an 8-bit word with a done pulse. Optional W/Y complement check: MUX151_WCHECK_EN.
module mux151_scan_ctrl #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       mux_y,
  input  logic       mux_w,
  output logic       mux_g,
  output logic [2:0] mux_a,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       err
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mux_a_q, mux_a_d;
  logic          mux_g_q, mux_g_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dir_q, dir_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    data_q, data_d;
  logic          last_ch;

`ifdef MUX151_WCHECK_EN
  logic flag_q, flag_d;
  logic err_q, err_d;
`else
  logic unused_mux_w;
  assign unused_mux_w = mux_w;
`endif

  assign last_ch = dir_q ? (mux_a_q == 3'd0) : (mux_a_q == 3'd7);

  always_comb begin
    // NOTE: every signal gets a default from its register first, so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mux_a_d = mux_a_q;
    mux_g_d = mux_g_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cap_d   = cap_q;
    data_d  = data_q;
`ifdef MUX151_WCHECK_EN
    flag_d  = flag_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          mux_g_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          mux_a_d = mode ? 3'd7 : 3'd0;
          dir_d   = mode;
          cap_d   = '0;
`ifdef MUX151_WCHECK_EN
          flag_d  = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Sample edge: the address has been held for SETTLE_CYC cycles.
          cap_d[mux_a_q] = mux_y;
`ifdef MUX151_WCHECK_EN
          flag_d = flag_q | (mux_w == mux_y);
`endif
          if (last_ch) begin
            state_d = ST_IDLE;
            mux_g_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = cap_d;
`ifdef MUX151_WCHECK_EN
            err_d   = flag_d;
`endif
          end else begin
            mux_a_d = dir_q ? (mux_a_q - 3'd1) : (mux_a_q + 3'd1);
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        mux_g_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mux_a_q <= 3'd0;
      mux_g_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cap_q   <= '0;
      data_q  <= '0;
`ifdef MUX151_WCHECK_EN
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mux_a_q <= mux_a_d;
      mux_g_q <= mux_g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
`ifdef MUX151_WCHECK_EN
      flag_q  <= flag_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mux_g = mux_g_q;
  assign mux_a = mux_a_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign data  = data_q;
`ifdef MUX151_WCHECK_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_mux151_scan_ctrl.sv
// Bench for mux151_scan_ctrl: two instances (SETTLE_CYC=1 and 3) driven against a
// scan-level model with a per-cycle compare, plus directed literal checks.
module tb_mux151_scan_ctrl;

  localparam int S_A = 1;
  localparam int S_B = 3;
`ifdef MUX151_WCHECK_EN
  localparam bit WCHK = 1'b1;
`else
  localparam bit WCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, mode, force_w;
  logic [7:0] d [2];

  logic       g1, b1, dn1, e1, y1, w1;
  logic [2:0] a1;
  logic [7:0] q1;
  logic       g3, b3, dn3, e3, y3, w3;
  logic [2:0] a3;
  logic [7:0] q3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Selector model: Y = D[A] while strobed, W = ~Y unless a fault is forced on channel 5.
  assign y1 = g1 ? 1'b0 : d[0][a1];
  assign w1 = (force_w[0] && a1 == 3'd5) ? y1 : ~y1;
  assign y3 = g3 ? 1'b0 : d[1][a3];
  assign w3 = (force_w[1] && a3 == 3'd5) ? y3 : ~y3;

  mux151_scan_ctrl #(.SETTLE_CYC(S_A)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]), .mux_y(y1), .mux_w(w1),
    .mux_g(g1), .mux_a(a1), .busy(b1), .done(dn1), .data(q1), .err(e1)
  );

  mux151_scan_ctrl #(.SETTLE_CYC(S_B)) u_dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]), .mux_y(y3), .mux_w(w3),
    .mux_g(g3), .mux_a(a3), .busy(b3), .done(dn3), .data(q3), .err(e3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan-level model: elapsed edges since accept determine channel and sample points.
  bit         m_busy [2];
  int         m_e    [2];
  bit         m_dir  [2];
  logic [7:0] m_cap  [2];
  logic [7:0] m_data [2];
  bit         m_flag [2];
  bit         m_err  [2];
  bit         m_done [2];
  logic [2:0] m_a    [2];

  always @(posedge clk or posedge rst) begin : model
    int s, ch;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? S_A : S_B;
      if (rst) begin
        m_busy[i] = 0; m_e[i] = 0; m_dir[i] = 0; m_cap[i] = 0; m_data[i] = 0;
        m_flag[i] = 0; m_err[i] = 0; m_done[i] = 0; m_a[i] = 0;
      end else begin
        m_done[i] = 0;
        if (!m_busy[i]) begin
          if (start[i]) begin
            m_busy[i] = 1; m_e[i] = 0; m_dir[i] = mode[i]; m_cap[i] = 0; m_flag[i] = 0;
            m_a[i] = mode[i] ? 3'd7 : 3'd0;
          end
        end else begin
          ch = m_dir[i] ? 7 - m_e[i] / s : m_e[i] / s;
          if (m_e[i] % s == s - 1) begin
            m_cap[i][ch] = d[i][ch];
            if (force_w[i] && ch == 5) m_flag[i] = 1;
          end
          m_e[i]++;
          if (m_e[i] == 8 * s) begin
            m_busy[i] = 0; m_done[i] = 1; m_data[i] = m_cap[i];
            m_err[i] = WCHK ? m_flag[i] : 1'b0;
          end else begin
            ch = m_dir[i] ? 7 - m_e[i] / s : m_e[i] / s;
            m_a[i] = 3'(ch);
          end
        end
      end
    end
  end

  task automatic cmp(input int i, input logic g, input logic [2:0] a, input logic b,
                     input logic dn, input logic [7:0] q, input logic e);
    check($sformatf("dut%0d mux_g", i), 32'(g), 32'(!m_busy[i]));
    check($sformatf("dut%0d mux_a", i), 32'(a), 32'(m_a[i]));
    check($sformatf("dut%0d busy", i), 32'(b), 32'(m_busy[i]));
    check($sformatf("dut%0d done", i), 32'(dn), 32'(m_done[i]));
    check($sformatf("dut%0d data", i), 32'(q), 32'(m_data[i]));
    check($sformatf("dut%0d err", i), 32'(e), 32'(m_err[i]));
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      cmp(0, g1, a1, b1, dn1, q1, e1);
      cmp(1, g3, a3, b3, dn3, q3, e3);
    end
  end

  function automatic logic done_of(input int i);
    return (i == 0) ? dn1 : dn3;
  endfunction

  // Launch a scan; mid-scan start pulse and mode flip must both be ignored.
  task automatic scan(input int i, input bit md, input logic [7:0] dv, input bit hold,
                      output int cyc);
    bit seen;
    mode[i] = md; d[i] = dv; start[i] = 1'b1; cyc = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (!hold && cyc == 1) start[i] = 1'b0;
      if (cyc == 4) begin start[i] = 1'b1; mode[i] = ~md; end
      if (!hold && cyc == 5) start[i] = 1'b0;
      if (done_of(i)) seen = 1;
    end
    check($sformatf("dut%0d done within bound", i), 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int i, output int cyc);
    bit seen;
    cyc = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done_of(i)) seen = 1;
    end
    check($sformatf("dut%0d done within bound", i), 32'(seen), 32'd1);
  endtask

  initial begin
    int cyc, ndone;
    start = 0; mode = 0; force_w = 0; d[0] = 0; d[1] = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset mux_g", 32'(g1), 32'd1);
    check("reset mux_a", 32'(a1), 32'd0);
    check("reset data", 32'(q3), 32'd0);

    // SETTLE_CYC=1, ascending, D=A5
    scan(0, 1'b0, 8'hA5, 1'b0, cyc);
    check("s1 latency", 32'(cyc), 32'd9);
    check("s1 data", 32'(q1), 32'hA5);
    check("s1 err", 32'(e1), 32'd0);
    check("s1 mux_a end", 32'(a1), 32'd7);

    // SETTLE_CYC=3, descending, D=3C
    @(negedge clk);
    scan(1, 1'b1, 8'h3C, 1'b0, cyc);
    check("s3 latency", 32'(cyc), 32'd25);
    check("s3 data", 32'(q3), 32'h3C);
    check("s3 mux_a end", 32'(a3), 32'd0);

    // Back-to-back with start held through the done cycle
    @(negedge clk);
    scan(0, 1'b0, 8'h5A, 1'b1, cyc);
    check("b2b first data", 32'(q1), 32'h5A);
    check("b2b done cycle mux_g", 32'(g1), 32'd1);
    d[0] = 8'h0F;
    @(negedge clk);
    start[0] = 1'b0;
    check("b2b restart mux_g", 32'(g1), 32'd0);
    check("b2b restart busy", 32'(b1), 32'd1);
    wait_done(0, cyc);
    check("b2b second latency", 32'(cyc), 32'd8);
    check("b2b second data", 32'(q1), 32'h0F);

    // W/Y complement fault on channel 5, then a clean scan
    @(negedge clk);
    force_w[0] = 1'b1;
    scan(0, 1'b0, 8'hFF, 1'b0, cyc);
    check("wchk data", 32'(q1), 32'hFF);
    check("wchk err", 32'(e1), 32'(WCHK));
    force_w[0] = 1'b0;
    @(negedge clk);
    scan(0, 1'b1, 8'h81, 1'b0, cyc);
    check("clean data", 32'(q1), 32'h81);
    check("clean err", 32'(e1), 32'd0);

    // Asynchronous reset mid-scan at channel 4
    @(negedge clk);
    mode[1] = 1'b1; d[1] = 8'hC3; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    cyc = 0;
    while (cyc < 40 && a3 != 3'd4) begin
      @(negedge clk);
      cyc++;
    end
    check("reach channel 4", 32'(a3), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async rst mux_g", 32'(g3), 32'd1);
    check("async rst mux_a", 32'(a3), 32'd0);
    check("async rst busy", 32'(b3), 32'd0);
    check("async rst done", 32'(dn3), 32'd0);
    check("async rst data", 32'(q3), 32'h00);
    check("async rst err", 32'(e3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn3) ndone++;
    end
    check("no done after abort", 32'(ndone), 32'd0);
    check("data held after abort", 32'(q3), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
